// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - borrow_in (mod 2^N) one bit per
// cycle, LSB first. The result and final borrow are registered on completion
// and marked by a one-cycle done pulse.
// Optional feature: define SERIAL_SUB_OVF_EN to add the 'overflow' output
// (two's-complement overflow of the subtraction).
module serial_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         borrow_in,
    output logic [N-1:0] diff,
    output logic         borrow_out,
    output logic         busy,
    output logic         done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         overflow
`endif
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   a_sh_q, a_sh_d;
    logic [N-1:0]   b_sh_q, b_sh_d;
    logic [N-1:0]   res_q, res_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           br_q, br_d;
    logic           borrow_out_q, borrow_out_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           bit_d;
    logic           br_next;
    logic [N-1:0]   res_shifted;
    logic           last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic           a_msb_q, a_msb_d;
    logic           b_msb_q, b_msb_d;
    logic           overflow_q, overflow_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy       = (state_q == SHIFT);
        done       = (state_q == DONE);
        diff       = diff_q;
        borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        overflow   = overflow_q;
`endif
    end

    // Datapath: operand capture, one full-subtractor step per SHIFT cycle,
    // result publication on the final bit
    always_comb begin
        bit_d        = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_next      = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_shifted  = {bit_d, res_q[N-1:1]};
        last_bit     = (cnt_q == LAST);

        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        br_d         = br_q;
        cnt_d        = cnt_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        overflow_d   = overflow_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a;
                    b_sh_d = b;
                    br_d   = borrow_in;
                    res_d  = '0;
                    cnt_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[N-1];
                    b_msb_d = b[N-1];
`endif
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                br_d   = br_next;
                res_d  = res_shifted;
                cnt_d  = last_bit ? '0 : cnt_q + CW'(1);
                if (last_bit) begin
                    diff_d       = res_shifted;
                    borrow_out_d = br_next;
`ifdef SERIAL_SUB_OVF_EN
                    // bit_d is the MSB of the finished difference
                    overflow_d   = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
`endif
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            br_q         <= 1'b0;
            cnt_q        <= '0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            overflow_q   <= 1'b0;
`endif
        end else begin
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            br_q         <= br_d;
            cnt_q        <= cnt_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            overflow_q   <= overflow_d;
`endif
        end
    end

endmodule
